// File: rtl/myproject_dense_pkg.sv
// Shared types and constants for the dense-layer accumulator and its requantiser.
package myproject_dense_pkg;

    localparam int PROD_W = 23;
    localparam int OUT_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_BIAS  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Smallest accumulator width that cannot overflow for n_in full-scale products.
    function automatic int min_acc_w(input int n_in);
        return PROD_W + $clog2(n_in) + 1;
    endfunction

endpackage

// File: rtl/myproject_dense_requant.sv
// Arithmetic right shift of the accumulator to the output format, then saturate
// (MYPROJECT_ACC_SAT_EN defined) or wrap to 16 bits, flagging out-of-range values.
module myproject_dense_requant
    import myproject_dense_pkg::*;
#(
    parameter int ACC_W = 34,
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [OUT_W-1:0] res,
    output logic                    ovf
);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] r_s;

    // Floor shift, range check and reduction to the output width.
    always_comb begin
        r_s = acc >>> SHIFT;
        ovf = (r_s > MAX_V) || (r_s < MIN_V);
`ifdef MYPROJECT_ACC_SAT_EN
        if (r_s > MAX_V) begin
            res = MAX_V[OUT_W-1:0];
        end else if (r_s < MIN_V) begin
            res = MIN_V[OUT_W-1:0];
        end else begin
            res = r_s[OUT_W-1:0];
        end
`else
        res = r_s[OUT_W-1:0];
`endif
    end

endmodule

// File: rtl/myproject_dense_accum_23s_16s.sv
// Dense-layer accumulator: sums a group of signed 23-bit products, adds bias,
// requantises to 16 bits and holds the result under valid/ack. Optional: MYPROJECT_ACC_SAT_EN.
module myproject_dense_accum_23s_16s
    import myproject_dense_pkg::*;
#(
    parameter int N_IN      = 16,
    parameter int ACC_W     = 34,
    parameter int PROD_FRAC = 10,
    parameter int BIAS_FRAC = 6,
    parameter int OUT_FRAC  = 6
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic signed [PROD_W-1:0] prod_din,
    input  logic                    prod_vld,
    input  logic                    prod_last,
    output logic                    prod_rdy,
    input  logic signed [OUT_W-1:0] bias_din,
    output logic signed [OUT_W-1:0] res_dout,
    output logic                    res_vld,
    input  logic                    res_ack,
    output logic                    err_len,
    output logic                    err_ovf
);

    localparam int CNT_W    = $clog2(N_IN + 1);
    localparam int BIAS_SH  = PROD_FRAC - BIAS_FRAC;
    localparam int OUT_SH   = PROD_FRAC - OUT_FRAC;
    localparam logic [CNT_W-1:0] N_MAX = CNT_W'(N_IN);

    state_t                  state_r, state_next_s;
    logic signed [ACC_W-1:0] acc_r;
    logic [CNT_W-1:0]        cnt_r;
    logic signed [OUT_W-1:0] bias_r;
    logic signed [OUT_W-1:0] res_dout_r;
    logic                    res_vld_r;
    logic                    err_len_r;
    logic                    err_ovf_r;

    logic                    prod_rdy_s;
    logic                    accept_s;
    logic [CNT_W-1:0]        cnt_next_s;
    logic                    hit_max_s;
    logic                    close_s;
    logic signed [ACC_W-1:0] prod_ext_s;
    logic signed [ACC_W-1:0] bias_ext_s;
    logic signed [ACC_W-1:0] acc_base_s;
    logic signed [OUT_W-1:0] req_res_s;
    logic                    req_ovf_s;

    assign accept_s   = prod_vld & prod_rdy_s;
    assign cnt_next_s = (state_r == ST_IDLE) ? CNT_W'(1) : (cnt_r + CNT_W'(1));
    assign hit_max_s  = (cnt_next_s == N_MAX);
    // A group closes on an explicit last beat or when it reaches the beat limit.
    assign close_s    = accept_s & (prod_last | hit_max_s);
    assign prod_ext_s = {{(ACC_W-PROD_W){prod_din[PROD_W-1]}}, prod_din};
    assign bias_ext_s = $signed({{(ACC_W-OUT_W){bias_r[OUT_W-1]}}, bias_r}) <<< BIAS_SH;
    assign acc_base_s = (state_r == ST_IDLE) ? {ACC_W{1'b0}} : acc_r;

    myproject_dense_requant #(
        .ACC_W (ACC_W),
        .SHIFT (OUT_SH)
    ) u_requant (
        .acc (acc_r),
        .res (req_res_s),
        .ovf (req_ovf_s)
    );

    // State register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (close_s) begin
                    state_next_s = ST_BIAS;
                end else if (accept_s) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (close_s) begin
                    state_next_s = ST_BIAS;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_BIAS: state_next_s = ST_OUT;
            ST_OUT: begin
                if (res_vld_r && res_ack) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: products are taken only while collecting a group.
    always_comb begin
        prod_rdy_s = 1'b0;
        case (state_r)
            ST_IDLE:  prod_rdy_s = 1'b1;
            ST_ACCUM: prod_rdy_s = 1'b1;
            ST_BIAS:  prod_rdy_s = 1'b0;
            ST_OUT:   prod_rdy_s = 1'b0;
            default:  prod_rdy_s = 1'b0;
        endcase
    end

    // Datapath: accumulate, add bias, capture the requantised result and sticky flags.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            acc_r      <= {ACC_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            bias_r     <= {OUT_W{1'b0}};
            res_dout_r <= {OUT_W{1'b0}};
            res_vld_r  <= 1'b0;
            err_len_r  <= 1'b0;
            err_ovf_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ACCUM: begin
                    if (accept_s) begin
                        acc_r <= acc_base_s + prod_ext_s;
                        cnt_r <= cnt_next_s;
                        if (close_s) begin
                            bias_r <= bias_din;
                        end
                        if (hit_max_s && !prod_last) begin
                            err_len_r <= 1'b1;
                        end
                    end
                end
                ST_BIAS: begin
                    acc_r <= acc_r + bias_ext_s;
                end
                ST_OUT: begin
                    if (!res_vld_r) begin
                        res_dout_r <= req_res_s;
                        res_vld_r  <= 1'b1;
                        if (req_ovf_s) begin
                            err_ovf_r <= 1'b1;
                        end
                    end else if (res_ack) begin
                        res_vld_r <= 1'b0;
                        acc_r     <= {ACC_W{1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
                    end
                end
                default: begin
                    acc_r <= {ACC_W{1'b0}};
                end
            endcase
        end
    end

    assign prod_rdy = prod_rdy_s;
    assign res_dout = res_dout_r;
    assign res_vld  = res_vld_r;
    assign err_len  = err_len_r;
    assign err_ovf  = err_ovf_r;

endmodule

// File: doc/myproject_dense_accum_23s_16s.md
# myproject_dense_accum_23s_16s

Dense-layer accumulator that sits directly downstream of the 16s×7ns→23-bit product multipliers. It consumes a stream of signed 23-bit products for one output neuron and sums them in a wide accumulator. It adds the neuron bias, rescales to the layer's output fixed-point format, and presents one 16-bit signed result per group under a valid/ack handshake.

## Interface
Parameters:
- `N_IN`, 16: maximum products per group (1..1024).
- `ACC_W`, 34: accumulator width; at least 23 + clog2(N_IN) + 1.
- `PROD_FRAC`, 10: fractional bits of incoming products.
- `BIAS_FRAC`, 6: fractional bits of `bias_din`; must be ≤ PROD_FRAC.
- `OUT_FRAC`, 6: fractional bits of `res_dout`; must be ≤ PROD_FRAC.

Ports (one clock; reset is synchronous and active-high):
- `ap_clk`  in  1  clock, rising edge.
- `ap_rst`  in  1  synchronous active-high reset.
- `prod_din`  in  23  signed product.
- `prod_vld`  in  1  product valid.
- `prod_last`  in  1  final product of the group.
- `prod_rdy`  out  1  block accepts a product this cycle.
- `bias_din`  in  16  signed bias; sampled on the cycle the last beat is accepted.
- `res_dout`  out  16  signed result.
- `res_vld`  out  1  result valid.
- `res_ack`  in  1  consumer takes the result.
- `err_len`  out  1  sticky flag: a group hit N_IN beats without `prod_last`.
- `err_ovf`  out  1  sticky flag: the output exceeded 16-bit range.

## Operation
- The FSM has four states: IDLE, ACCUM, BIAS, OUT.
- A beat is accepted when `prod_vld & prod_rdy`. `prod_rdy` = 1 in IDLE and ACCUM, and 0 in BIAS and OUT.
- **IDLE:**
  - An accepted beat loads `acc = sext(prod_din)` and sets `cnt = 1`.
  - The next state is ACCUM, or BIAS if the beat is last.
- **ACCUM:**
  - An accepted beat does `acc += sext(prod_din)` and `cnt++`.
  - It moves to BIAS on `prod_last`, or when `cnt` reaches N_IN. The N_IN case also sets `err_len`.
- **BIAS:**
  - `acc += sext(bias_reg) <<< (PROD_FRAC − BIAS_FRAC)`.
  - Then `r = acc >>> (PROD_FRAC − OUT_FRAC)`, truncating toward −∞.
  - `r` is reduced to 16 bits (see Configuration) and registered into `res_dout`. The next state is OUT.
- **OUT:**
  - `res_vld` = 1 and `res_dout` is held stable until `res_ack`.
  - On ack the block returns to IDLE and `acc` and `cnt` clear.
- Sticky flags clear only on `ap_rst`.

## Timing
- **Reset values:** state = IDLE, `acc` = 0, `cnt` = 0, `res_dout` = 0, `res_vld` = 0, `err_len` = 0, `err_ovf` = 0. `prod_rdy` = 1 in the first cycle after reset.
- **Throughput:** one product per cycle during accumulation.
- **Latency:** if the last beat is accepted at edge k, `res_vld` rises after edge k+2.
- **Ack timing:** an ack at edge m returns the block to IDLE. `prod_rdy` = 1 in cycle m+1. Minimum group-to-group gap is 3 cycles.
- **Single-beat group:** a beat with `prod_vld & prod_last` in IDLE is a one-beat group.
- `prod_last` is ignored when `prod_vld` = 0.
- **Reset mid-operation:** `ap_rst` in any state discards the partial sum and any pending result. `res_vld` drops on the next edge.

## Configuration
- With `MYPROJECT_ACC_SAT_EN` defined:
  - `r` saturates to the range [−32768, 32767].
  - `err_ovf` is set whenever clamping occurs.
- Without the macro:
  - `r` wraps to its low 16 bits.
  - `err_ovf` is still set on out-of-range values.

## Structure
- **Shared package `myproject_dense_pkg`:**
  - The FSM state enum.
  - `PROD_W` = 23 and `OUT_W` = 16.
  - A function computing the minimum `ACC_W` from `N_IN`.
- **Sub-module `myproject_dense_requant`:**
  - Combinational shift, then saturate or wrap, plus overflow detection.
  - Instantiated once, and reused later by other layers.

## Test plan
Default parameters (shift 4, bias shift 4) unless noted.
1. **Basic group:** products 1024, 2048, −512 (last), bias 64 → `res_dout` = 224 exactly 2 cycles after the last beat; `err_*` = 0.
2. **Floor truncation:** single beat −17 with `prod_last`, bias 0 → `res_dout` = −2.
3. **Overflow:** four beats of 4194303, bias 0. With `MYPROJECT_ACC_SAT_EN`: `res_dout` = 32767 and `err_ovf` = 1. Without it: `res_dout` = −1 and `err_ovf` = 1.
4. **Backpressure:** hold `res_ack` = 0 for 5 cycles → `res_dout` is stable, `prod_rdy` = 0 throughout, no beats lost. The next group is accepted 1 cycle after ack.
5. **Length error:** with N_IN = 4, send 4 beats of 16 with no `prod_last`, bias 0 → the group closes and `res_dout` = 4. `err_len` = 1 and stays 1 across later groups until reset.
6. **Reset mid-group:** accept 2 beats of 1024, pulse `ap_rst`, then send a single beat 160 with last and bias 0 → `res_dout` = 10, with no stale sum.
